i2c_write_engine: RTL

- Executes one 24-bit I2C write on the codec control bus: START, three bytes MSB-first (device address + R/W, register high byte, register low byte), an ACK slot after each byte, then STOP.
- The codec initialization sequencer loads each configuration word into this engine and waits for the completion pulse before loading the next word.
- Drives the SCL and SDA pins. The tristate buffer at the top level uses the engine's SDA output-enable.

---
 rtl/i2c_write_engine.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/i2c_write_engine.sv
// Single 24-bit I2C write (START, three bytes each followed by an ACK slot, STOP) for the codec control bus.
// Pin outputs are registered from next-state values so SCL/SDA never glitch.
module i2c_write_engine #(
    parameter int unsigned CLK_DIV = 30
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_data,
    input  logic        i_sdat,
    output logic        o_sclk,
    output logic        o_sdat,
    output logic        o_oen,
    output logic        o_busy,
    output logic        o_finished,
    output logic        o_ack_err
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [1:0]       q, q_nxt;
    logic [23:0]      shift, shift_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [1:0]       byte_cnt, byte_nxt;
    logic             ack_err, ack_err_nxt;
    logic             tick;
    logic             sclk_d, sdat_d, oen_d, busy_d, fin_d;

    assign tick      = (div_cnt == DIV_LAST);
    assign o_ack_err = ack_err;

    // State, timebase, datapath and registered pin outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            q          <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            ack_err    <= 1'b0;
            o_sclk     <= 1'b1;
            o_sdat     <= 1'b1;
            o_oen      <= 1'b1;
            o_busy     <= 1'b0;
            o_finished <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            q          <= q_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_nxt;
            byte_cnt   <= byte_nxt;
            ack_err    <= ack_err_nxt;
            o_sclk     <= sclk_d;
            o_sdat     <= sdat_d;
            o_oen      <= oen_d;
            o_busy     <= busy_d;
            o_finished <= fin_d;
        end
    end

    // Next-state, quarter timebase and datapath updates
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        q_nxt       = q;
        shift_nxt   = shift;
        bit_nxt     = bit_cnt;
        byte_nxt    = byte_cnt;
        ack_err_nxt = ack_err;

        if (state != S_IDLE && state != S_DONE) begin
            if (tick) begin
                div_nxt = '0;
                q_nxt   = q + 2'd1;
            end else begin
                div_nxt = div_cnt + DIV_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    shift_nxt   = i_data;
                    ack_err_nxt = 1'b0;
                    bit_nxt     = '0;
                    byte_nxt    = '0;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                if (tick && q == 2'd1) state_nxt = S_BIT;
            end
            S_BIT: begin
                if (tick && q == 2'd3) begin
                    shift_nxt = {shift[22:0], 1'b0};
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // ack_err doubles as the sampled NACK for the decision one quarter later
                if (tick && q == 2'd2 && i_sdat) ack_err_nxt = 1'b1;
                if (tick && q == 2'd3) begin
                    if (ack_err || byte_cnt == 2'd2) begin
                        state_nxt = S_STOP;
                    end else begin
                        byte_nxt  = byte_cnt + 2'd1;
                        state_nxt = S_BIT;
                    end
                end
            end
            S_STOP: begin
                if (tick && q == 2'd3) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt != state) begin
            div_nxt = '0;
            q_nxt   = '0;
        end
    end

    // Pin values for the upcoming cycle, decoded from next-state values
    always_comb begin
        sclk_d = 1'b1;
        sdat_d = 1'b1;
        oen_d  = 1'b1;
        busy_d = 1'b1;
        fin_d  = 1'b0;
        case (state_nxt)
            S_IDLE:  busy_d = 1'b0;
            S_START: sdat_d = (q_nxt == 2'd0);
            S_BIT: begin
                sclk_d = q_nxt[1];
                sdat_d = shift_nxt[23];
            end
            S_ACK: begin
                sclk_d = q_nxt[1];
                oen_d  = 1'b0;
            end
            S_STOP: begin
                sclk_d = (q_nxt != 2'd0);
                sdat_d = q_nxt[1];
            end
            S_DONE:  fin_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

endmodule
